regfile_scoreboard: RTL

- Parametrised successor to the 2-read/1-write register file. Generalised data width and depth.
- Clocks writes on the rising edge. Same-cycle write-to-read bypass is built in.
- Adds a per-register busy scoreboard so the decode stage can detect RAW hazards against in-flight producers.
- Sits between decode (read/allocate) and writeback (write/release).

---
 rtl/regfile_scoreboard_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 96 +++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bundle for the register file with busy scoreboard.
// master: the pipeline driving addresses, writebacks and allocations.
// slave:  the register file answering with read data, busy bits and count.
`timescale 1ns/1ps
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              alloc_en;
    logic [ADDR_W-1:0] alloc_addr;
    logic              flush;
    logic [ADDR_W:0]   busy_count;

    modport master (
        output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
               alloc_en, alloc_addr, flush,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_count
    );

    modport slave (
        input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
               alloc_en, alloc_addr, flush,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with same-cycle write bypass and a per-register
// busy scoreboard (set on allocate, cleared on writeback, cleared en masse by
// flush). busy_count tracks the number of busy registers incrementally.
`timescale 1ns/1ps
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic                 clk,
    input logic                 reset,
    regfile_scoreboard_if.slave rf
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              wr_ok;
    logic              alloc_ok;
    logic              inc;
    logic              dec;

    // Qualify write/alloc (register 0 is hardwired when ZERO_REG is set) and
    // compute next busy vector and count; alloc is applied after clear/flush.
    always_comb begin
        wr_ok    = rf.wr_en    && !((ZERO_REG != 0) && (rf.wr_addr    == '0));
        alloc_ok = rf.alloc_en && !((ZERO_REG != 0) && (rf.alloc_addr == '0));
        inc      = 1'b0;
        dec      = 1'b0;

        busy_d = rf.flush ? '0 : busy_q;
        if (wr_ok)
            busy_d[rf.wr_addr] = 1'b0;
        if (alloc_ok)
            busy_d[rf.alloc_addr] = 1'b1;

        if (rf.flush) begin
            count_d = {{ADDR_W{1'b0}}, alloc_ok};
        end else begin
            inc     = alloc_ok && !busy_q[rf.alloc_addr];
            dec     = wr_ok && busy_q[rf.wr_addr] &&
                      !(alloc_ok && (rf.alloc_addr == rf.wr_addr));
            count_d = count_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
        end
    end

    // Combinational read ports: stored value, overridden by bypass, then by reg 0.
    always_comb begin
        rf.rs1_data = regs_q[rf.rs1_addr];
        rf.rs1_busy = busy_q[rf.rs1_addr];
        if ((BYPASS != 0) && rf.wr_en && (rf.rs1_addr == rf.wr_addr)) begin
            rf.rs1_data = rf.wr_data;
            rf.rs1_busy = 1'b0;
        end
        if ((ZERO_REG != 0) && (rf.rs1_addr == '0)) begin
            rf.rs1_data = '0;
            rf.rs1_busy = 1'b0;
        end

        rf.rs2_data = regs_q[rf.rs2_addr];
        rf.rs2_busy = busy_q[rf.rs2_addr];
        if ((BYPASS != 0) && rf.wr_en && (rf.rs2_addr == rf.wr_addr)) begin
            rf.rs2_data = rf.wr_data;
            rf.rs2_busy = 1'b0;
        end
        if ((ZERO_REG != 0) && (rf.rs2_addr == '0)) begin
            rf.rs2_data = '0;
            rf.rs2_busy = 1'b0;
        end

        rf.busy_count = count_q;
    end

    // Register storage: cleared on reset, one write per cycle otherwise.
    always_ff @(posedge clk) begin
        if (reset)
            regs_q <= '{default: '0};
        else if (wr_ok)
            regs_q[rf.wr_addr] <= rf.wr_data;
    end

    // Scoreboard state and busy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end
endmodule
